vram_scan_arbiter: RTL
======================

Name: vram_scan_arbiter

Overview:
- Shares a single-port synchronous video RAM between the CPU bus and the display scan-out for the PAL timing generator.
- Consumes the generator's horizontal/vertical counters and reserves one RAM slot per 8-pixel group for display fetch.
- Grants all other slots to CPU read/write requests through a req/ack handshake.
- Serialises fetched bytes into a 1bpp pixel stream, MSB first.

Parameters:
- H_START, 96, cntHS value of first visible pixel; must be a multiple of 8 and at least 8.
- V_START, 40, cntVS value of first visible line.
- V_HEIGHT, 192, number of visible lines; at most 256.
- FB_BASE, 0, framebuffer base byte address (13 bits).
- Fixed geometry: 256 pixels/line = 32 bytes/line; ADDR_W = 13.

Ports:
- pixel_clk  in  1  pixel clock, only clock in the block.
- rst  in  1  synchronous reset, active-high.
- cntHS  in  9  horizontal counter from the timing generator (0..511).
- cntVS  in  9  vertical counter from the timing generator (0..311).
- cpu_req  in  1  CPU access request, held until ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  13  CPU byte address; stable while cpu_req is high.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data; valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_addr  out  13  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data; 1-cycle latency, registered in RAM.
- pixel  out  1  video pixel, registered.
- active  out  1  registered; 1 when pixel is inside the visible window.

Behaviour:
- Window decode:
  - y = cntVS − V_START; vis_line = cntVS in [V_START, V_START+V_HEIGHT).
  - vis_px = vis_line and cntHS in [H_START, H_START+256).
- fetch_slot (combinational): vis_line and cntHS[2:0] = 0 and cntHS in [H_START−8, H_START+248).
  - Byte index k = (cntHS − H_START + 8) >> 3, range 0..31.
  - Fetch address = FB_BASE + {y[7:0], k[4:0]}.
  - Exactly 32 fetch slots per visible line; none on other lines.
- Memory mux (combinational):
  - In fetch_slot, mem_addr = fetch address and mem_we = 0. Display always wins.
  - Else, on a CPU grant cycle, mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
  - Otherwise mem_we = 0 and mem_addr = 0.
- Fetch pipeline:
  - fetch_pend register = fetch_slot delayed 1 cycle.
  - When fetch_pend = 1, fetch_buf <= mem_rdata.
- Shifter, per clock:
  - If vis_px and cntHS[2:0] = 0: pixel <= fetch_buf[7]; shreg <= {fetch_buf[6:0], 0}.
  - Else if vis_px: pixel <= shreg[7]; shreg <= shreg << 1.
  - Else pixel <= 0.
  - active <= vis_px.
  - Pixel latency: 1 cycle after the corresponding cntHS value.
- CPU FSM, states IDLE, WAIT, ACK:
  - IDLE: cpu_req = 1 and fetch_slot = 0 is a grant (RAM driven with the CPU access this cycle); go to WAIT. If fetch_slot = 1, stay in IDLE; the grant is deferred.
  - WAIT: if !cpu_we, cpu_rdata <= mem_rdata. cpu_ack <= 1. Go to ACK. A fetch slot may occur in WAIT; the RAM port is free then.
  - ACK: cpu_ack = 1 for exactly this cycle; go to IDLE. Requester drops cpu_req during ACK.
  - If cpu_req is still high on return to IDLE, it is treated as a new request.
  - Worst-case grant latency 1 cycle; access-to-ack 2 cycles.
- Writes also complete with ack; cpu_rdata holds its previous value on writes.
- Reset:
  - State IDLE, cpu_ack = 0, cpu_rdata = 0, pixel = 0, active = 0, shreg = 0, fetch_buf = 0, fetch_pend = 0.
  - Reset mid-transaction aborts the access with no ack. A write already issued on the grant cycle has already occurred.
- Boundaries:
  - Last fetch at cntHS = H_START+240.
  - Frame wrap, cntVS 311→0: no fetch, no state carried over.
  - cntHS 511→0 with no fetch in progress: nothing carried over.

Test Plan:
- Reset, run one full line at cntVS = V_START+3 -> 32 fetch reads at cntHS = 88, 96, …, 336 with mem_addr = 96..127; no other display accesses.
- RAM byte 0x60 = 0xA5, line at cntVS = 43 -> pixel sequence 1,0,1,0,0,1,0,1 on cycles after cntHS = 96..103; active high for cntHS 96..351 (delayed 1 cycle); pixel = 0 outside.
- CPU write addr 0x1234, data 0x5A, during cntVS = 0 -> grant same cycle (mem_we = 1, mem_addr = 0x1234), cpu_ack two cycles later, one-cycle pulse.
- CPU read asserted at cntHS = 104 on a visible line -> grant deferred to cntHS = 105; cpu_rdata = RAM[cpu_addr] with ack at 107; fetch data for that slot is still correct.
- CPU read granted at cntHS = 111, next cycle is a fetch slot -> fetch_buf receives the fetch byte, cpu_rdata receives the CPU byte; no cross-contamination.
- rst asserted during WAIT -> no ack; all outputs 0 next cycle; a new request after rst deasserts completes normally.

Source files
------------

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares a single-port VRAM between CPU req/ack accesses and 1bpp display scan-out
module vram_scan_arbiter #(
  parameter int H_START = 96,
  parameter int V_START = 40,
  parameter int V_HEIGHT = 192,
  parameter logic [12:0] FB_BASE = 13'd0
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [8:0]  cntHS,
  input  logic [8:0]  cntVS,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        pixel,
  output logic        active
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, state_nx;
  logic vis_line, vis_px, fetch_slot, fetch_pend, grant;
  logic [7:0] y, fetch_buf, shreg;
  logic [4:0] k;
  logic [12:0] fetch_addr;
  assign vis_line = cntVS >= 9'(V_START) && {1'b0, cntVS} < 10'(V_START + V_HEIGHT);
  assign vis_px = vis_line && cntHS >= 9'(H_START) && {1'b0, cntHS} < 10'(H_START + 256);
  assign fetch_slot = vis_line && cntHS[2:0] == 3'd0 && cntHS >= 9'(H_START - 8) && {1'b0, cntHS} < 10'(H_START + 248);
  assign y = 8'(cntVS - 9'(V_START));
  assign k = 5'((cntHS - 9'(H_START - 8)) >> 3);
  assign fetch_addr = FB_BASE + {y, k};
  assign grant = state == IDLE && cpu_req && !fetch_slot;
  assign mem_addr = fetch_slot ? fetch_addr : grant ? cpu_addr : '0;
  assign mem_we = grant && cpu_we;
  assign mem_wdata = grant ? cpu_wdata : '0;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (grant ? WAIT : IDLE) : state == WAIT ? ACK : IDLE;
  end
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state <= IDLE;
      cpu_ack <= 1'b0;
      cpu_rdata <= '0;
      pixel <= 1'b0;
      active <= 1'b0;
      shreg <= '0;
      fetch_buf <= '0;
      fetch_pend <= 1'b0;
    end else begin
      state <= state_nx;
      fetch_pend <= fetch_slot;
      if (fetch_pend) fetch_buf <= mem_rdata;
      cpu_ack <= state == WAIT;
      if (state == WAIT && !cpu_we) cpu_rdata <= mem_rdata;
      active <= vis_px;
      pixel <= vis_px && (cntHS[2:0] == 3'd0 ? fetch_buf[7] : shreg[7]);
      if (vis_px) shreg <= cntHS[2:0] == 3'd0 ? {fetch_buf[6:0], 1'b0} : shreg << 1;
    end
  end
endmodule
